// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter for a shared vending datapath: grants one kiosk,
// latches its item, accumulates coin credit and ends the session with a vend or refund.
module vend_session_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [6*N_REQ-1:0] item_in,
  input  logic               coin_valid,
  input  logic [6:0]         coin_val,
  input  logic               cancel,
  input  logic [7:0]         price,
  output logic [N_REQ-1:0]   gnt,
  output logic [5:0]         sel_item,
  output logic               add_more,
  output logic [7:0]         credit,
  output logic               vend_valid,
  output logic               refund_valid,
  output logic [7:0]         change,
  output logic               coin_reject
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [5:0]         sel_q, sel_d;
  logic [7:0]         credit_q, credit_d;
  logic               add_more_q, add_more_d;
  logic               vend_q, vend_d;
  logic               refund_q, refund_d;
  logic [7:0]         change_q, change_d;
  logic               reject_q, reject_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [N_REQ-1:0][5:0] items;
  logic                  found;
  logic [IDX_W-1:0]      pick;
  logic [8:0]            sum;
  logic                  tmo_hit;

  assign items   = item_in;
  assign sum     = {1'b0, credit_q} + {2'b00, coin_val};
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Round-robin search starting just above the last granted kiosk.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      logic [IDX_W-1:0] k;
      k = IDX_W'((32'(last_q) + i) % N_REQ);
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    credit_d   = credit_q;
    add_more_d = 1'b0;
    vend_d     = 1'b0;
    refund_d   = 1'b0;
    change_d   = 8'd0;
    reject_d   = 1'b0;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        gnt_d    = '0;
        credit_d = 8'd0;
        if (found) begin
          state_d    = S_COLLECT;
          gnt_d      = N_REQ'(1) << pick;
          last_d     = pick;
          sel_d      = items[pick];
          tmo_d      = '0;
          add_more_d = 1'b1;
        end
      end

      S_COLLECT: begin
        if (price == 8'd0) begin
          state_d  = S_REFUND;
          refund_d = 1'b1;
          change_d = credit_q;
        end else if (coin_valid && sum[8]) begin
          // Refused coin does not count as activity for the timeout.
          reject_d   = 1'b1;
          add_more_d = (credit_q < price);
          if (!tmo_hit) tmo_d = tmo_q + TMO_W'(1);
        end else if (coin_valid) begin
          credit_d = sum[7:0];
          tmo_d    = '0;
          if (sum[7:0] >= price) begin
            state_d  = S_VEND;
            vend_d   = 1'b1;
            change_d = sum[7:0] - price;
          end else if (cancel) begin
            state_d  = S_REFUND;
            refund_d = 1'b1;
            change_d = sum[7:0];
          end else begin
            add_more_d = 1'b1;
          end
        end else if (cancel || tmo_hit) begin
          state_d  = S_REFUND;
          refund_d = 1'b1;
          change_d = credit_q;
        end else begin
          tmo_d      = tmo_q + TMO_W'(1);
          add_more_d = (credit_q < price);
        end
      end

      S_VEND, S_REFUND: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        credit_d = 8'd0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(N_REQ - 1);
      gnt_q      <= '0;
      sel_q      <= 6'd0;
      credit_q   <= 8'd0;
      add_more_q <= 1'b0;
      vend_q     <= 1'b0;
      refund_q   <= 1'b0;
      change_q   <= 8'd0;
      reject_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      credit_q   <= credit_d;
      add_more_q <= add_more_d;
      vend_q     <= vend_d;
      refund_q   <= refund_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      tmo_q      <= tmo_d;
    end
  end

  assign gnt          = gnt_q;
  assign sel_item     = sel_q;
  assign add_more     = add_more_q;
  assign credit       = credit_q;
  assign vend_valid   = vend_q;
  assign refund_valid = refund_q;
  assign change       = change_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Scoreboard bench for vend_session_arbiter: directed sessions push expected
// vend/refund/reject events; a negedge monitor pops and compares them.
module tb_vend_session_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int K_VEND   = 0;
  localparam int K_REFUND = 1;
  localparam int K_REJECT = 2;

  typedef struct {
    int       kind;
    int       item;
    int       chg;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [6*N_REQ-1:0] item_in;
  logic               coin_valid;
  logic [6:0]         coin_val;
  logic               cancel;
  logic [7:0]         price;
  logic [N_REQ-1:0]   gnt;
  logic [5:0]         sel_item;
  logic               add_more;
  logic [7:0]         credit;
  logic               vend_valid;
  logic               refund_valid;
  logic [7:0]         change;
  logic               coin_reject;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  vend_session_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .item_in(item_in),
    .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel), .price(price),
    .gnt(gnt), .sel_item(sel_item), .add_more(add_more), .credit(credit),
    .vend_valid(vend_valid), .refund_valid(refund_valid), .change(change),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  // Price lookup model
  always_comb begin
    case (sel_item)
      6'd0:    price = 8'd0;
      6'd4:    price = 8'd25;
      6'd9:    price = 8'd200;
      6'd12:   price = 8'd255;
      default: price = 8'd50;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int item, input int chg);
    exp_t e;
    e.kind = kind; e.item = item; e.chg = chg;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_val   = 7'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  // Request a session for kiosk k on item it, check the grant, then drop req.
  task automatic start(input int k, input int it);
    item_in = '0;
    item_in[6*k +: 6] = 6'(it);
    req = '0;
    req[k] = 1'b1;
    tick();
    chk("start_gnt", int'(gnt), 1 << k);
    chk("start_item", int'(sel_item), it);
    req = '0;
  endtask

  task automatic cancel_session(input int it, input int chg);
    cancel = 1'b1;
    push(K_REFUND, it, chg);
    tick();
    cancel = 1'b0;
    tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot", int'($countones(gnt) <= 1), 1);
      if (vend_valid && refund_valid) chk("vend_refund_excl", 1, 0);
      if (vend_valid || refund_valid || coin_reject) begin
        int ak;
        exp_t e;
        ak = vend_valid ? K_VEND : (refund_valid ? K_REFUND : K_REJECT);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", ak, -1);
        end else begin
          e = exp_q.pop_front();
          chk("evt_kind", ak, e.kind);
          if (ak != K_REJECT) begin
            chk("evt_item", int'(sel_item), e.item);
            chk("evt_change", int'(change), e.chg);
            chk("evt_gnt_held", int'(gnt != 0), 1);
          end
        end
      end
    end
  end

  initial begin
    int n;
    bit got;
    rst = 1'b1; req = '0; item_in = '0; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_vend", int'(vend_valid), 0);
    chk("rst_change", int'(change), 0);
    rst = 1'b0;

    // Basic vend on kiosk 0, item 4 (price 25)
    start(0, 4);
    chk("entry_add_more", int'(add_more), 1);
    coin(5);
    chk("c5_credit", int'(credit), 5);
    chk("c5_add_more", int'(add_more), 1);
    push(K_VEND, 4, 30);
    coin(50);
    chk("vend_pulse", int'(vend_valid), 1);
    tick();
    chk("post_vend_gnt", int'(gnt), 0);
    chk("post_vend_pulse", int'(vend_valid), 0);

    // Round-robin order from reset
    rst = 1'b1; tick(); rst = 1'b0;
    item_in = {4{6'd4}};
    req = 4'b0110;
    tick();
    chk("rr_first", int'(gnt), 4'b0010);
    cancel = 1'b1; push(K_REFUND, 4, 0); tick(); cancel = 1'b0;
    tick();
    chk("rr_gap", int'(gnt), 0);
    tick();
    chk("rr_second", int'(gnt), 4'b0100);
    req = 4'b0011;
    cancel = 1'b1; push(K_REFUND, 4, 0); tick(); cancel = 1'b0;
    tick(); tick();
    chk("rr_third", int'(gnt), 4'b0001);
    req = '0;
    cancel_session(4, 0);

    // Cancel refund with credit
    start(2, 9);
    coin(10); coin(10);
    chk("pre_cancel_credit", int'(credit), 20);
    cancel_session(9, 20);

    // Timeout refund after 16 idle cycles
    start(1, 9);
    coin(10);
    push(K_REFUND, 9, 10);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (refund_valid) got = 1'b1;
    end
    chk("timeout_cycles", n, 16);
    tick();

    // Overflowing coin refused (item 12, price 255)
    start(3, 12);
    coin(127); coin(123);
    chk("pre_rej_credit", int'(credit), 250);
    push(K_REJECT, 0, 0);
    coin(10);
    chk("rej_pulse", int'(coin_reject), 1);
    chk("rej_credit", int'(credit), 250);
    chk("rej_add_more", int'(add_more), 1);
    cancel_session(12, 250);

    // Completing coin beats simultaneous cancel
    start(0, 9);
    coin(100);
    cancel = 1'b1;
    push(K_VEND, 9, 0);
    coin(100);
    cancel = 1'b0;
    chk("race_vend", int'(vend_valid), 1);
    tick();

    // Invalid item refunds immediately
    push(K_REFUND, 0, 0);
    start(1, 0);
    tick();
    chk("item0_refund", int'(refund_valid), 1);
    tick();

    // Reset mid-session drops it silently
    start(0, 9);
    coin(10); coin(20);
    chk("pre_rst_credit", int'(credit), 30);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_credit", int'(credit), 0);
    chk("mid_rst_refund", int'(refund_valid), 0);
    chk("mid_rst_add_more", int'(add_more), 0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_gnt", int'(gnt), 0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
